i2c_wb_cmd_seq: RTL and testbench

Command sequencer that sits directly upstream of the Wishbone I2C master core and drives its register file. It accepts one byte-level register command at a time (slave address, register index, data, direction) and converts it into the Wishbone write/poll/read sequence the core needs. It then returns read data and error status. It replaces hand-written bus-functional register pokes with one synthesizable front end.

---
 rtl/i2c_wb_cmd_seq.sv | 352 +++++++++++++++++++++++++++++++++++
 tb/tb_i2c_wb_cmd_seq.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_wb_cmd_seq.sv
// i2c_wb_cmd_seq: turns one byte-level I2C register command into the
// write/poll/read sequence of the Wishbone I2C master core register file,
// then reports read data and error status.
module i2c_wb_cmd_seq #(
  parameter logic [15:0] PRESCALE   = 16'd99,
  parameter logic [15:0] POLL_LIMIT = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       arst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i
);

  // Core register addresses
  localparam logic [2:0] ADR_TXR = 3'd3;  // TXR on write, RXR on read
  localparam logic [2:0] ADR_CR  = 3'd4;  // CR on write, SR on read

  // Command register values
  localparam logic [7:0] CTR_EN         = 8'h80;
  localparam logic [7:0] CR_STA_WR      = 8'h90;
  localparam logic [7:0] CR_WR          = 8'h10;
  localparam logic [7:0] CR_WR_STO      = 8'h50;
  localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
  localparam logic [7:0] CR_STO         = 8'h40;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_AL      = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ACCESS, S_POLL, S_CHECK, S_ABORT, S_RESP
  } state_t;

  state_t      state_reg, state_next;
  // INIT: which init write; ACCESS: 0 TXR write, 1 CR write, 2 RXR read;
  // ABORT: 0 STOP write, 1 Busy poll
  logic [1:0]  phase_reg, phase_next;
  // Step 0..2 shared by both directions, 3 = read byte, 4 = fetch RXR
  logic [2:0]  step_reg, step_next;
  logic [15:0] poll_cnt_reg, poll_cnt_next;
  logic        sr_al_reg, sr_al_next;
  logic        sr_rxack_reg, sr_rxack_next;

  logic        rw_reg, rw_next;
  logic [6:0]  addr_reg, addr_next;
  logic [7:0]  reg_reg, reg_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  rdata_reg, rdata_next;
  logic [1:0]  err_reg, err_next;

  // Wishbone master registers; done_reg pulses the cycle after ack
  logic        stb_reg, stb_next;
  logic        we_reg, we_next;
  logic [2:0]  adr_reg, adr_next;
  logic [7:0]  dat_reg, dat_next;
  logic        done_reg, done_next;
  logic [7:0]  rdat_reg, rdat_next;

  logic        bus_free;
  logic        req;
  logic        req_we;
  logic [2:0]  req_adr;
  logic [7:0]  req_dat;
  logic [7:0]  txr_val;
  logic [7:0]  cr_val;
  logic        poll_last;

  // The done cycle keeps stb low for one cycle between accesses
  assign bus_free  = !stb_reg && !done_reg;
  assign poll_last = ({1'b0, poll_cnt_reg} + 17'd1) >= {1'b0, POLL_LIMIT};

  assign cmd_ready = (state_reg == S_IDLE);
  assign rsp_valid = (state_reg == S_RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign wb_adr_o  = adr_reg;
  assign wb_dat_o  = dat_reg;
  assign wb_we_o   = we_reg;
  assign wb_stb_o  = stb_reg;
  assign wb_cyc_o  = stb_reg;

  // TXR and CR values for the current step of the command
  always_comb begin
    txr_val = {addr_reg, 1'b0};
    cr_val  = CR_STA_WR;
    case (step_reg)
      3'd1: begin
        txr_val = reg_reg;
        cr_val  = CR_WR;
      end
      3'd2: begin
        txr_val = rw_reg ? {addr_reg, 1'b1} : wdata_reg;
        cr_val  = rw_reg ? CR_STA_WR : CR_WR_STO;
      end
      3'd3: begin
        txr_val = {addr_reg, 1'b1};
        cr_val  = CR_RD_NACK_STO;
      end
      default: begin
        txr_val = {addr_reg, 1'b0};
        cr_val  = CR_STA_WR;
      end
    endcase
  end

  // Sequencer next-state, bus request and response logic
  always_comb begin
    state_next    = state_reg;
    phase_next    = phase_reg;
    step_next     = step_reg;
    poll_cnt_next = poll_cnt_reg;
    sr_al_next    = sr_al_reg;
    sr_rxack_next = sr_rxack_reg;
    rw_next       = rw_reg;
    addr_next     = addr_reg;
    reg_next      = reg_reg;
    wdata_next    = wdata_reg;
    rdata_next    = rdata_reg;
    err_next      = err_reg;
    stb_next      = stb_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    done_next     = 1'b0;
    rdat_next     = rdat_reg;
    req           = 1'b0;
    req_we        = 1'b0;
    req_adr       = 3'd0;
    req_dat       = 8'h00;

    // Access completes: drop strobe, capture read data
    if (stb_reg && wb_ack_i) begin
      stb_next  = 1'b0;
      we_next   = 1'b0;
      done_next = 1'b1;
      rdat_next = wb_dat_i;
    end

    case (state_reg)
      S_INIT: begin
        if (done_reg) begin
          if (phase_reg == 2'd2) begin
            phase_next = 2'd0;
            state_next = S_IDLE;
          end else begin
            phase_next = phase_reg + 2'd1;
          end
        end else if (bus_free) begin
          req     = 1'b1;
          req_we  = 1'b1;
          req_adr = {1'b0, phase_reg};
          case (phase_reg)
            2'd0:    req_dat = PRESCALE[7:0];
            2'd1:    req_dat = PRESCALE[15:8];
            default: req_dat = CTR_EN;
          endcase
        end
      end

      S_IDLE: begin
        if (cmd_valid) begin
          rw_next    = cmd_rw;
          addr_next  = cmd_addr;
          reg_next   = cmd_reg;
          wdata_next = cmd_wdata;
          rdata_next = 8'h00;
          err_next   = ERR_OK;
          step_next  = 3'd0;
          phase_next = 2'd0;
          state_next = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (done_reg) begin
          case (phase_reg)
            2'd0: phase_next = 2'd1;
            2'd1: begin
              poll_cnt_next = 16'd0;
              state_next    = S_POLL;
            end
            default: begin
              rdata_next = rdat_reg;
              state_next = S_RESP;
            end
          endcase
        end else if (bus_free) begin
          req = 1'b1;
          case (phase_reg)
            2'd0: begin
              req_we  = 1'b1;
              req_adr = ADR_TXR;
              req_dat = txr_val;
            end
            2'd1: begin
              req_we  = 1'b1;
              req_adr = ADR_CR;
              req_dat = cr_val;
            end
            default: begin
              req_we  = 1'b0;
              req_adr = ADR_TXR;
            end
          endcase
        end
      end

      S_POLL: begin
        if (done_reg) begin
          sr_al_next    = rdat_reg[5];
          sr_rxack_next = rdat_reg[7];
          if (!rdat_reg[1]) begin
            state_next = S_CHECK;
          end else if (poll_last) begin
            err_next   = ERR_TIMEOUT;
            phase_next = 2'd0;
            state_next = S_ABORT;
          end else begin
            poll_cnt_next = poll_cnt_reg + 16'd1;
          end
        end else if (bus_free) begin
          req     = 1'b1;
          req_adr = ADR_CR;
        end
      end

      S_CHECK: begin
        if (sr_al_reg) begin
          // Bus is lost: the core no longer owns it, so no STOP
          err_next   = ERR_AL;
          state_next = S_RESP;
        end else if (sr_rxack_reg && (step_reg != 3'd3)) begin
          err_next   = ERR_NACK;
          phase_next = 2'd0;
          state_next = S_ABORT;
        end else begin
          state_next = S_ACCESS;
          step_next  = step_reg + 3'd1;
          phase_next = 2'd0;
          case (step_reg)
            3'd2: begin
              if (rw_reg) begin
                phase_next = 2'd1;  // read byte has no TXR load
              end else begin
                state_next = S_RESP;
              end
            end
            3'd3:    phase_next = 2'd2;
            3'd4:    state_next = S_RESP;
            default: phase_next = 2'd0;
          endcase
        end
      end

      S_ABORT: begin
        if (done_reg) begin
          if (phase_reg == 2'd0) begin
            phase_next    = 2'd1;
            poll_cnt_next = 16'd0;
          end else if (!rdat_reg[6] || poll_last) begin
            state_next = S_RESP;
          end else begin
            poll_cnt_next = poll_cnt_reg + 16'd1;
          end
        end else if (bus_free) begin
          req     = 1'b1;
          req_adr = ADR_CR;
          if (phase_reg == 2'd0) begin
            req_we  = 1'b1;
            req_dat = CR_STO;
          end
        end
      end

      S_RESP: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_INIT;
        phase_next = 2'd0;
      end
    endcase

    // Launch a new access; fields stay held until ack
    if (req) begin
      stb_next = 1'b1;
      we_next  = req_we;
      adr_next = req_adr;
      dat_next = req_dat;
    end
  end

  // State and output registers; reset drops strobe immediately
  always_ff @(posedge wb_clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_reg    <= S_INIT;
      phase_reg    <= 2'd0;
      step_reg     <= 3'd0;
      poll_cnt_reg <= 16'd0;
      sr_al_reg    <= 1'b0;
      sr_rxack_reg <= 1'b0;
      rw_reg       <= 1'b0;
      addr_reg     <= 7'd0;
      reg_reg      <= 8'h00;
      wdata_reg    <= 8'h00;
      rdata_reg    <= 8'h00;
      err_reg      <= ERR_OK;
      stb_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= 3'd0;
      dat_reg      <= 8'h00;
      done_reg     <= 1'b0;
      rdat_reg     <= 8'h00;
    end else begin
      state_reg    <= state_next;
      phase_reg    <= phase_next;
      step_reg     <= step_next;
      poll_cnt_reg <= poll_cnt_next;
      sr_al_reg    <= sr_al_next;
      sr_rxack_reg <= sr_rxack_next;
      rw_reg       <= rw_next;
      addr_reg     <= addr_next;
      reg_reg      <= reg_next;
      wdata_reg    <= wdata_next;
      rdata_reg    <= rdata_next;
      err_reg      <= err_next;
      stb_reg      <= stb_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      done_reg     <= done_next;
      rdat_reg     <= rdat_next;
    end
  end

endmodule

// File: tb/tb_i2c_wb_cmd_seq.sv
// Bench for i2c_wb_cmd_seq: behavioural I2C core + slave model, a
// transaction-level reference memory, and per-scenario test tasks.
module tb_i2c_wb_cmd_seq;

  localparam logic [6:0] SLAVE = 7'h10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'd0;
  logic [7:0] cmd_reg = 8'h00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i;
  logic       wb_we_o, wb_stb_o, wb_cyc_o, wb_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_wb_cmd_seq #(.PRESCALE(16'd99), .POLL_LIMIT(16'd8)) dut (
    .wb_clk_i(clk), .arst_i(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
    .wb_ack_i(wb_ack_i)
  );

  // ---------------- core + slave model ----------------
  logic [10:0] wlog[$];          // every acknowledged write: {adr, dat}
  int          sr_reads = 0;
  int          sr_at_abort = 0;  // SR reads seen when CR=0x40 arrived
  bit          force_tip = 1'b0;
  bit          force_al = 1'b0;
  logic [7:0]  txr = 8'h00, rxr = 8'h00, ptr = 8'h00;
  bit          bus_busy = 1'b0, addressed = 1'b0, dir = 1'b0, rxack = 1'b0;
  int          byte_idx = 0, tip_left = 0, wait_cnt = 0;
  logic [7:0]  slave_mem [int];

  function automatic logic [7:0] dflt(input logic [7:0] p);
    return p ^ 8'h5A;
  endfunction

  function automatic logic [7:0] slave_rd(input logic [7:0] p);
    return slave_mem.exists(int'(p)) ? slave_mem[int'(p)] : dflt(p);
  endfunction

  task automatic model_write(input logic [2:0] adr, input logic [7:0] dat);
    wlog.push_back({adr, dat});
    if (adr == 3'd3) txr = dat;
    else if (adr == 3'd4) begin
      if (dat == 8'h40) sr_at_abort = sr_reads;
      if (dat[7]) begin bus_busy = 1'b1; byte_idx = 0; end
      if (dat[4]) begin
        if (byte_idx == 0) begin
          addressed = (txr[7:1] == SLAVE);
          dir = txr[0];
        end else if (addressed && !dir) begin
          if (byte_idx == 1) ptr = txr;
          else slave_mem[int'(ptr)] = txr;
        end
        rxack = !addressed;
        byte_idx++;
      end
      if (dat[5]) begin
        rxr = addressed ? slave_rd(ptr) : 8'hFF;
        rxack = 1'b1;  // master NACKs the last byte
      end
      if (dat[6]) bus_busy = 1'b0;
      tip_left = $urandom_range(0, 3);
    end
  endtask

  task automatic model_read(input logic [2:0] adr, output logic [7:0] d);
    d = 8'h00;
    if (adr == 3'd3) d = rxr;
    else if (adr == 3'd4) begin
      d = {rxack, force_tip | bus_busy, force_al, 3'b000,
           force_tip | (tip_left > 0), 1'b0};
      sr_reads++;
      if (tip_left > 0) tip_left--;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] rd;
    if (!rst_n) begin
      wb_ack_i <= 1'b0;
      wb_dat_i <= 8'h00;
      wait_cnt = 0;
      tip_left = 0;
    end else begin
      wb_ack_i <= 1'b0;
      if (wb_stb_o && !wb_ack_i) begin
        if (wait_cnt > 0) wait_cnt--;
        else begin
          wait_cnt = $urandom_range(0, 2);
          wb_ack_i <= 1'b1;
          if (wb_we_o) model_write(wb_adr_o, wb_dat_o);
          else begin
            model_read(wb_adr_o, rd);
            wb_dat_i <= rd;
          end
        end
      end
    end
  end

  // ---------------- Wishbone protocol monitor ----------------
  int         wb_viol = 0;
  logic       p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0, p_rst = 1'b0;
  logic [2:0] p_adr = 3'd0;
  logic [7:0] p_dat = 8'h00;

  always @(negedge clk) begin
    if (rst_n && p_rst) begin
      if (wb_cyc_o !== wb_stb_o ||
          (p_stb && p_ack && wb_stb_o !== 1'b0) ||
          (p_stb && !p_ack && (wb_stb_o !== 1'b1 || wb_adr_o !== p_adr ||
                               wb_dat_o !== p_dat || wb_we_o !== p_we))) begin
        wb_viol++;
        if (wb_viol < 5)
          $display("FAIL wb_protocol t=%0t stb=%b cyc=%b adr=%0d dat=%h we=%b (prev stb=%b ack=%b adr=%0d dat=%h)",
                   $time, wb_stb_o, wb_cyc_o, wb_adr_o, wb_dat_o, wb_we_o, p_stb, p_ack, p_adr, p_dat);
      end
    end
    p_stb = wb_stb_o; p_ack = wb_ack_i; p_adr = wb_adr_o;
    p_dat = wb_dat_o; p_we = wb_we_o; p_rst = rst_n;
  end

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [int];
  logic [10:0] exp_q[$];

  function automatic logic [7:0] ref_rd(input logic [7:0] p);
    return ref_mem.exists(int'(p)) ? ref_mem[int'(p)] : dflt(p);
  endfunction

  // Expected core-register writes for a normally completing command
  task automatic build_exp(input bit rw, input logic [6:0] a,
                           input logic [7:0] r, input logic [7:0] d);
    exp_q.delete();
    exp_q.push_back({3'd3, a, 1'b0});
    exp_q.push_back({3'd4, 8'h90});
    if (a != SLAVE) begin
      exp_q.push_back({3'd4, 8'h40});
    end else begin
      exp_q.push_back({3'd3, r});
      exp_q.push_back({3'd4, 8'h10});
      if (rw) begin
        exp_q.push_back({3'd3, a, 1'b1});
        exp_q.push_back({3'd4, 8'h90});
        exp_q.push_back({3'd4, 8'h68});
      end else begin
        exp_q.push_back({3'd3, d});
        exp_q.push_back({3'd4, 8'h50});
      end
    end
  endtask

  task automatic build_init_exp();
    exp_q.delete();
    exp_q.push_back({3'd0, 8'h63});
    exp_q.push_back({3'd1, 8'h00});
    exp_q.push_back({3'd2, 8'h80});
  endtask

  // -1 when the log from base equals exp_q, -2 on count mismatch, else index
  function automatic int log_diff(input int base);
    if (wlog.size() - base != exp_q.size()) return -2;
    foreach (exp_q[i]) if (wlog[base + i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // Drives one command and returns what was observed
  task automatic send_cmd(input bit rw, input logic [6:0] a, input logic [7:0] r,
                          input logic [7:0] d, input bit hold_valid,
                          output logic [1:0] err, output logic [7:0] rd,
                          output int base, output bit tmo,
                          output logic ready_after, output logic valid_after);
    int n;
    tmo = 1'b0;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    base = wlog.size();
    cmd_rw = rw; cmd_addr = a; cmd_reg = r; cmd_wdata = d;
    cmd_valid = 1'b1;
    @(negedge clk);
    ready_after = cmd_ready;
    if (hold_valid) begin
      cmd_rw = ~rw; cmd_addr = ~a; cmd_reg = ~r; cmd_wdata = ~d;
    end else cmd_valid = 1'b0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (rsp_valid !== 1'b1) tmo = 1'b1;
    err = rsp_err;
    rd = rsp_rdata;
    cmd_valid = 1'b0;
    @(negedge clk);
    valid_after = rsp_valid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int base, n, dif;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({cmd_ready, rsp_valid, rsp_rdata, rsp_err, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o} !== '0) begin
      errors++;
      $display("FAIL reset_values: ready=%b valid=%b rdata=%h err=%0d stb=%b cyc=%b we=%b adr=%0d dat=%h, expected all 0",
               cmd_ready, rsp_valid, rsp_rdata, rsp_err, wb_stb_o, wb_cyc_o, wb_we_o, wb_adr_o, wb_dat_o);
    end
    base = wlog.size();
    rst_n = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL init_ready: cmd_ready=%b, expected 1", cmd_ready);
    end
    build_init_exp();
    dif = log_diff(base);
    checks++;
    if (dif !== -1) begin
      errors++;
      $display("FAIL init_writes: %0d writes seen (diff code %0d), expected 63@0 00@1 80@2 before ready",
               wlog.size() - base, dif);
    end
    $display("reset: init writes=%0d ready=%b", wlog.size() - base, cmd_ready);
  endtask

  task automatic test_write();
    logic [1:0] err; logic [7:0] rd; int base, dif; bit tmo; logic ra, va;
    send_cmd(1'b0, SLAVE, 8'h05, 8'hA5, 1'b0, err, rd, base, tmo, ra, va);
    ref_mem[5] = 8'hA5;
    build_exp(1'b0, SLAVE, 8'h05, 8'hA5);
    dif = log_diff(base);
    $display("write: addr=10 reg=05 wdata=A5 err=%0d rdata=%h writes=%0d", err, rd, wlog.size() - base);
    checks++;
    if (tmo !== 1'b0) begin errors++; $display("FAIL write_rsp_timeout: no rsp_valid"); end
    checks++;
    if (ra !== 1'b0) begin errors++; $display("FAIL ready_drop: cmd_ready=%b after accept, expected 0", ra); end
    checks++;
    if (va !== 1'b0) begin errors++; $display("FAIL rsp_pulse: rsp_valid=%b second cycle, expected 0", va); end
    checks++;
    if (err !== 2'd0 || rd !== 8'h00) begin
      errors++; $display("FAIL write_rsp: err=%0d rdata=%h, expected err=0 rdata=00", err, rd);
    end
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL write_seq: diff code %0d, expected TXR 20/05/A5 CR 90/10/50", dif); end
    checks++;
    if (slave_rd(8'h05) !== 8'hA5) begin
      errors++; $display("FAIL slave_mem: reg5=%h, expected A5", slave_rd(8'h05));
    end
  endtask

  task automatic test_read();
    logic [1:0] err; logic [7:0] rd; int base, dif; bit tmo; logic ra, va;
    send_cmd(1'b1, SLAVE, 8'h05, 8'h00, 1'b0, err, rd, base, tmo, ra, va);
    build_exp(1'b1, SLAVE, 8'h05, 8'h00);
    dif = log_diff(base);
    $display("read: addr=10 reg=05 err=%0d rdata=%h writes=%0d", err, rd, wlog.size() - base);
    checks++;
    if (tmo !== 1'b0 || err !== 2'd0 || rd !== ref_rd(8'h05)) begin
      errors++; $display("FAIL read_rsp: tmo=%b err=%0d rdata=%h, expected err=0 rdata=%h", tmo, err, rd, ref_rd(8'h05));
    end
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL read_seq: diff code %0d, expected ...21/90 then CR 68", dif); end
  endtask

  task automatic test_nack();
    logic [1:0] err; logic [7:0] rd; int base, dif; bit tmo; logic ra, va;
    send_cmd(1'b0, 7'h11, 8'h05, 8'h3C, 1'b0, err, rd, base, tmo, ra, va);
    build_exp(1'b0, 7'h11, 8'h05, 8'h3C);
    dif = log_diff(base);
    $display("nack: addr=11 err=%0d rdata=%h writes=%0d busy=%b", err, rd, wlog.size() - base, bus_busy);
    checks++;
    if (tmo !== 1'b0 || err !== 2'd1 || rd !== 8'h00) begin
      errors++; $display("FAIL nack_rsp: tmo=%b err=%0d rdata=%h, expected err=1 rdata=00", tmo, err, rd);
    end
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL nack_seq: diff code %0d, expected 22/90 then CR 40", dif); end
    checks++;
    if (bus_busy !== 1'b0) begin errors++; $display("FAIL nack_bus_idle: busy=%b, expected 0", bus_busy); end
  endtask

  task automatic test_arb_lost();
    logic [1:0] err; logic [7:0] rd; int base, dif; bit tmo; logic ra, va;
    force_al = 1'b1;
    // absent slave also NACKs: lost arbitration must take priority
    send_cmd(1'b1, 7'h11, 8'h07, 8'h00, 1'b0, err, rd, base, tmo, ra, va);
    force_al = 1'b0;
    exp_q.delete();
    exp_q.push_back({3'd3, 8'h22});
    exp_q.push_back({3'd4, 8'h90});
    dif = log_diff(base);
    $display("arb_lost: err=%0d rdata=%h writes=%0d", err, rd, wlog.size() - base);
    checks++;
    if (tmo !== 1'b0 || err !== 2'd2 || rd !== 8'h00) begin
      errors++; $display("FAIL al_rsp: tmo=%b err=%0d rdata=%h, expected err=2 rdata=00", tmo, err, rd);
    end
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL al_seq: diff code %0d, expected 22/90 and no STOP", dif); end
  endtask

  task automatic test_timeout();
    logic [1:0] err; logic [7:0] rd; int base, dif, sr0; bit tmo; logic ra, va;
    sr0 = sr_reads;
    force_tip = 1'b1;
    send_cmd(1'b0, SLAVE, 8'h02, 8'h77, 1'b0, err, rd, base, tmo, ra, va);
    force_tip = 1'b0;
    exp_q.delete();
    exp_q.push_back({3'd3, 8'h20});
    exp_q.push_back({3'd4, 8'h90});
    exp_q.push_back({3'd4, 8'h40});
    dif = log_diff(base);
    $display("timeout: err=%0d polls_before_stop=%0d writes=%0d", err, sr_at_abort - sr0, wlog.size() - base);
    checks++;
    if (tmo !== 1'b0 || err !== 2'd3) begin
      errors++; $display("FAIL timeout_rsp: tmo=%b err=%0d, expected err=3", tmo, err);
    end
    checks++;
    if (sr_at_abort - sr0 !== 8) begin
      errors++; $display("FAIL timeout_polls: %0d SR reads before CR 40, expected 8", sr_at_abort - sr0);
    end
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL timeout_seq: diff code %0d, expected 20/90 then CR 40", dif); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] err, exp_err; logic [7:0] rd, exp_rd, r, d; logic [6:0] a;
    int base, dif; bit tmo, rw, hold; logic ra, va;
    for (int i = 0; i < 16; i++) begin
      rw = 1'($urandom);
      hold = 1'($urandom);
      r = 8'($urandom_range(0, 7));
      d = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a = SLAVE;
      else begin
        a = 7'($urandom);
        if (a == SLAVE) a = 7'h11;
      end
      exp_err = (a == SLAVE) ? 2'd0 : 2'd1;
      exp_rd = (a == SLAVE && rw) ? ref_rd(r) : 8'h00;
      if (a == SLAVE && !rw) ref_mem[int'(r)] = d;
      build_exp(rw, a, r, d);
      send_cmd(rw, a, r, d, hold, err, rd, base, tmo, ra, va);
      dif = log_diff(base);
      $display("b2b[%0d]: rw=%0d addr=%h reg=%h wdata=%h hold=%0d err=%0d rdata=%h",
               i, rw, a, r, d, hold, err, rd);
      checks++;
      if (tmo !== 1'b0 || err !== exp_err || rd !== exp_rd) begin
        errors++; $display("FAIL b2b_rsp[%0d]: tmo=%b err=%0d rdata=%h, expected err=%0d rdata=%h",
                           i, tmo, err, rd, exp_err, exp_rd);
      end
      checks++;
      if (dif !== -1) begin errors++; $display("FAIL b2b_seq[%0d]: diff code %0d", i, dif); end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] err; logic [7:0] rd; int base, dif, n; bit tmo; logic ra, va;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    cmd_rw = 1'b0; cmd_addr = SLAVE; cmd_reg = 8'h33; cmd_wdata = 8'hC3;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!(wb_stb_o === 1'b1 && wb_we_o === 1'b1 && wb_adr_o === 3'd3 && wb_dat_o === 8'h33) && n < 500) begin
      @(negedge clk); n++;
    end
    checks++;
    if (wb_stb_o !== 1'b1 || wb_dat_o !== 8'h33) begin
      errors++; $display("FAIL mid_step2_reached: stb=%b dat=%h, expected TXR write of 33", wb_stb_o, wb_dat_o);
    end
    #2 rst_n = 1'b0;
    #1;
    $display("reset_mid: stb=%b cyc=%b ready=%b right after reset", wb_stb_o, wb_cyc_o, cmd_ready);
    checks++;
    if (wb_stb_o !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset_async: stb=%b cyc=%b ready=%b, expected 0 0 0", wb_stb_o, wb_cyc_o, cmd_ready);
    end
    repeat (3) @(negedge clk);
    base = wlog.size();
    rst_n = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    build_init_exp();
    dif = log_diff(base);
    checks++;
    if (dif !== -1) begin errors++; $display("FAIL mid_init_rerun: diff code %0d, expected 3 init writes", dif); end
    send_cmd(1'b0, SLAVE, 8'h33, 8'h9E, 1'b0, err, rd, base, tmo, ra, va);
    ref_mem[8'h33] = 8'h9E;
    $display("reset_mid: follow-up write err=%0d reg33=%h", err, slave_rd(8'h33));
    checks++;
    if (tmo !== 1'b0 || err !== 2'd0 || slave_rd(8'h33) !== ref_rd(8'h33)) begin
      errors++; $display("FAIL mid_next_write: tmo=%b err=%0d reg33=%h, expected err=0 reg33=%h",
                         tmo, err, slave_rd(8'h33), ref_rd(8'h33));
    end
  endtask

  task automatic test_wb_protocol();
    checks++;
    if (wb_viol !== 0) begin
      errors++; $display("FAIL wb_protocol_total: %0d violations, expected 0", wb_viol);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_nack();
    test_arb_lost();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_wb_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
